// File: rtl/layer_input_feeder_pkg.sv
// -----------------------------------------------------------------------------
// layer_input_feeder_pkg
// Shared definitions for the layer input feeder and its FIFO:
//   - clog2       : ceiling log2, never below 1 (index/pointer widths)
//   - word_width  : data word width from float size plus Flopoco extra bits
//   - extra_bits_legal : only 0 or 2 extra bits are supported
//   - fifo_flags_t: full/empty status bundle exported by the FIFO
// -----------------------------------------------------------------------------
package layer_input_feeder_pkg;

    typedef struct packed {
        logic full;
        logic empty;
    } fifo_flags_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int word_width(input int bit_width, input int extra_bits);
        return bit_width + extra_bits;
    endfunction

    function automatic bit extra_bits_legal(input int extra_bits);
        return (extra_bits == 0) || (extra_bits == 2);
    endfunction

endpackage

// File: rtl/layer_input_feeder_fifo.sv
// -----------------------------------------------------------------------------
// feeder_fifo
// First-word-fall-through synchronous FIFO. The head entry is always visible
// on o_rd_data; a read request consumes it. Writes are ignored when full and
// reads are ignored when empty, so callers may drive the requests freely.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   i_wr_en    : write request, i_wr_data : word to store
//   i_rd_en    : consume head entry, o_rd_data : head entry (combinational)
//   o_flags    : full / empty status
// -----------------------------------------------------------------------------
module feeder_fifo
    import layer_input_feeder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output fifo_flags_t      o_flags
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("feeder_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = i_wr_en && !w_full;
    assign w_pop   = i_rd_en && !w_empty;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_flags   = '{full: w_full, empty: w_empty};

endmodule

// File: rtl/layer_input_feeder.sv
// -----------------------------------------------------------------------------
// layer_input_feeder
// Buffers the serialized neuron-output stream and presents it word by word to
// the next layer's ALUs, tagged with its position in the layer vector.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   shift_res     : incoming word, shift_valid : word present, shift_ready : space
//   alu_in        : head word, alu_in_valid : head present, alu_in_ready : consume
//   in_index      : position of alu_in in the layer vector
//   in_last       : alu_in is the final word of the vector
//   layer_done    : one-cycle pulse after the final word is consumed
//   ovf_err       : sticky, a word was offered while the FIFO was full
// -----------------------------------------------------------------------------
module layer_input_feeder
    import layer_input_feeder_pkg::*;
#(
    parameter  int NUM_INPUTS = 2,
    parameter  int BIT_WIDTH  = 32,
    parameter  int EXTRA_BITS = 0,
    parameter  int FIFO_DEPTH = 4,
    localparam int W          = word_width(BIT_WIDTH, EXTRA_BITS),
    localparam int IW         = clog2(NUM_INPUTS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  shift_res,
    input  logic          shift_valid,
    output logic          shift_ready,
    output logic [W-1:0]  alu_in,
    output logic          alu_in_valid,
    input  logic          alu_in_ready,
    output logic [IW-1:0] in_index,
    output logic          in_last,
    output logic          layer_done,
    output logic          ovf_err
);

    generate
        if (!extra_bits_legal(EXTRA_BITS)) begin : g_bad_extra
            $error("layer_input_feeder: EXTRA_BITS must be 0 or 2");
        end
        if (NUM_INPUTS < 2) begin : g_bad_inputs
            $error("layer_input_feeder: NUM_INPUTS must be at least 2");
        end
    endgenerate

    fifo_flags_t   w_flags;
    logic          w_pop;
    logic          w_last;
    logic [IW-1:0] r_idx;
    logic          r_layer_done;
    logic          r_ovf;

    feeder_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (shift_valid),
        .i_wr_data (shift_res),
        .i_rd_en   (alu_in_ready),
        .o_rd_data (alu_in),
        .o_flags   (w_flags)
    );

    assign shift_ready  = !w_flags.full;
    assign alu_in_valid = !w_flags.empty;
    assign w_pop        = alu_in_valid && alu_in_ready;
    assign w_last       = (r_idx == IW'(NUM_INPUTS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx        <= '0;
            r_layer_done <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_layer_done <= w_pop && w_last;
            if (w_pop) begin
                r_idx <= w_last ? '0 : r_idx + IW'(1);
            end
            // A word offered at full is dropped by the FIFO; remember it.
            if (shift_valid && !shift_ready) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign in_index   = r_idx;
    assign in_last    = w_last;
    assign layer_done = r_layer_done;
    assign ovf_err    = r_ovf;

endmodule

// File: tb/tb_layer_input_feeder.sv
module tb_layer_input_feeder;

    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    // Instance A: NUM_INPUTS=2, W=32
    logic [31:0] a_sd;
    logic        a_sv;
    logic        a_ar;
    logic        a_shift_ready;
    logic [31:0] a_alu_in;
    logic        a_alu_in_valid;
    logic [0:0]  a_in_index;
    logic        a_in_last;
    logic        a_layer_done;
    logic        a_ovf_err;

    // Instance B: NUM_INPUTS=3, EXTRA_BITS=2, W=34
    logic [33:0] b_sd;
    logic        b_sv;
    logic        b_ar;
    logic        b_shift_ready;
    logic [33:0] b_alu_in;
    logic        b_alu_in_valid;
    logic [1:0]  b_in_index;
    logic        b_in_last;
    logic        b_layer_done;
    logic        b_ovf_err;

    layer_input_feeder #(
        .NUM_INPUTS (2), .BIT_WIDTH (32), .EXTRA_BITS (0), .FIFO_DEPTH (DEPTH)
    ) dut_a (
        .clk (clk), .rst (rst),
        .shift_res (a_sd), .shift_valid (a_sv), .shift_ready (a_shift_ready),
        .alu_in (a_alu_in), .alu_in_valid (a_alu_in_valid), .alu_in_ready (a_ar),
        .in_index (a_in_index), .in_last (a_in_last),
        .layer_done (a_layer_done), .ovf_err (a_ovf_err)
    );

    layer_input_feeder #(
        .NUM_INPUTS (3), .BIT_WIDTH (32), .EXTRA_BITS (2), .FIFO_DEPTH (DEPTH)
    ) dut_b (
        .clk (clk), .rst (rst),
        .shift_res (b_sd), .shift_valid (b_sv), .shift_ready (b_shift_ready),
        .alu_in (b_alu_in), .alu_in_valid (b_alu_in_valid), .alu_in_ready (b_ar),
        .in_index (b_in_index), .in_last (b_in_last),
        .layer_done (b_layer_done), .ovf_err (b_ovf_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a queue of words plus a consumption counter per instance.
    logic [31:0] a_q[$];
    logic [33:0] b_q[$];
    int          a_idx, b_idx;
    bit          a_ovf, b_ovf, a_ld, b_ld;
    int          b_pushed;
    int          b_ld_seen;

    int errors;
    int checks;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        a_q.delete();
        b_q.delete();
        a_idx = 0; b_idx = 0;
        a_ovf = 0; b_ovf = 0;
        a_ld  = 0; b_ld  = 0;
    endtask

    task automatic cmp_all();
        chk("a_shift_ready", 64'(a_shift_ready), 64'(a_q.size() != DEPTH));
        chk("a_valid", 64'(a_alu_in_valid), 64'(a_q.size() != 0));
        if (a_q.size() != 0) chk("a_data", 64'(a_alu_in), 64'(a_q[0]));
        chk("a_index", 64'(a_in_index), 64'(a_idx));
        chk("a_last", 64'(a_in_last), 64'(a_idx == 1));
        chk("a_layer_done", 64'(a_layer_done), 64'(a_ld));
        chk("a_ovf", 64'(a_ovf_err), 64'(a_ovf));
        chk("b_shift_ready", 64'(b_shift_ready), 64'(b_q.size() != DEPTH));
        chk("b_valid", 64'(b_alu_in_valid), 64'(b_q.size() != 0));
        if (b_q.size() != 0) chk("b_data", 64'(b_alu_in), 64'(b_q[0]));
        chk("b_index", 64'(b_in_index), 64'(b_idx));
        chk("b_last", 64'(b_in_last), 64'(b_idx == 2));
        chk("b_layer_done", 64'(b_layer_done), 64'(b_ld));
        chk("b_ovf", 64'(b_ovf_err), 64'(b_ovf));
        if (b_layer_done === 1'b1) b_ld_seen++;
    endtask

    // One clock: inputs are stable across the edge, model advances, then compare.
    task automatic step();
        bit a_push, a_pop, b_push, b_pop;
        @(posedge clk);
        a_push = a_sv && (a_q.size() != DEPTH);
        a_pop  = a_ar && (a_q.size() != 0);
        a_ld   = a_pop && (a_idx == 1);
        if (a_sv && a_q.size() == DEPTH) a_ovf = 1;
        if (a_pop) begin
            void'(a_q.pop_front());
            a_idx = (a_idx + 1) % 2;
        end
        if (a_push) a_q.push_back(a_sd);

        b_push = b_sv && (b_q.size() != DEPTH);
        b_pop  = b_ar && (b_q.size() != 0);
        b_ld   = b_pop && (b_idx == 2);
        if (b_sv && b_q.size() == DEPTH) b_ovf = 1;
        if (b_pop) begin
            void'(b_q.pop_front());
            b_idx = (b_idx + 1) % 3;
        end
        if (b_push) begin
            b_q.push_back(b_sd);
            b_pushed++;
        end
        #1;
        cmp_all();
    endtask

    // Reset asserted between edges: outputs must clear without a clock.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        cmp_all();
        @(posedge clk);
        #1;
        cmp_all();
        rst = 1'b0;
    endtask

    task automatic idle_a();
        a_sv = 1'b0; a_ar = 1'b0; a_sd = '0;
    endtask

    task automatic push_a(input logic [31:0] d, input logic rdy);
        a_sv = 1'b1; a_sd = d; a_ar = rdy;
        step();
    endtask

    initial begin
        errors = 0; checks = 0;
        b_pushed = 0; b_ld_seen = 0;
        rst = 1'b0;
        idle_a();
        b_sv = 1'b0; b_ar = 1'b0; b_sd = '0;
        model_reset();

        // Reset from power-up
        do_reset();

        // Normal flow
        push_a(32'hAAAA_AAAA, 1'b1);
        push_a(32'hBBBB_BBBB, 1'b1);
        a_sv = 1'b0;
        step();
        step();

        // Backpressure and overflow
        for (int i = 0; i < 4; i++) push_a(32'hEEEE_EEE0 + 32'(i), 1'b0);
        push_a(32'hFFFF_FFFF, 1'b0);
        a_sv = 1'b0; a_ar = 1'b1;
        for (int i = 0; i < 5; i++) step();

        // Simultaneous push/pop at count 2
        push_a(32'h1111_0001, 1'b0);
        push_a(32'h1111_0002, 1'b0);
        push_a(32'h1111_0003, 1'b1);
        push_a(32'h1111_0004, 1'b1);
        a_sv = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Reset mid-layer after one pop
        do_reset();
        push_a(32'h2222_0001, 1'b0);
        push_a(32'h2222_0002, 1'b0);
        a_sv = 1'b0; a_ar = 1'b1;
        step();
        chk("a_idx_before_reset", 64'(a_in_index), 64'd1);
        do_reset();
        push_a(32'h3333_0001, 1'b1);
        push_a(32'h3333_0002, 1'b1);
        a_sv = 1'b0;
        step();
        step();
        idle_a();

        // Instance B: six random words with random ready, indices wrap at 3
        b_pushed = 0; b_ld_seen = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (b_pushed >= 6 && b_q.size() == 0) break;
            b_sv = (b_pushed < 6) && ($urandom_range(0, 1) == 1);
            b_sd = {2'($urandom_range(0, 3)), 32'($urandom)};
            b_ar = ($urandom_range(0, 2) != 0);
            step();
        end
        b_sv = 1'b0; b_ar = 1'b0;
        step();
        chk("b_all_pushed", 64'(b_pushed), 64'd6);
        chk("b_drained", 64'(b_alu_in_valid), 64'd0);
        chk("b_layer_done_pulses", 64'(b_ld_seen), 64'd2);

        // Random traffic on instance A
        for (int cyc = 0; cyc < 300; cyc++) begin
            a_sv = ($urandom_range(0, 1) == 1);
            a_sd = 32'($urandom);
            a_ar = ($urandom_range(0, 3) != 0);
            step();
        end
        idle_a();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/layer_input_feeder.md
# layer_input_feeder

Downstream stage of the intermediate buffer. Accepts the serialized word stream (one neuron output per valid cycle) that the buffer shifts out, absorbs rate mismatch in a small FIFO, and presents each word to the next layer's ALUs. Each word carries its input index (weight address), a last-of-layer flag, and a one-cycle completion pulse once the whole layer vector has been consumed.

## Interface
Parameters:
- NUM_INPUTS, 2: words per layer vector (previous layer's NUM_NEURONS); ≥2.
- BIT_WIDTH, 32: floating-point size.
- EXTRA_BITS, 0: Flopoco extra bits; only 0 or 2 allowed.
- FIFO_DEPTH, 4: FIFO entries; power of two, ≥2.

Ports (W = BIT_WIDTH+EXTRA_BITS, IW = clog2(NUM_INPUTS)):
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- shift_res  in  W  serialized word from the intermediate buffer.
- shift_valid  in  1  shift_res valid this cycle.
- shift_ready  out  1  FIFO can accept a word.
- alu_in  out  W  head-of-FIFO word to the next-layer ALUs.
- alu_in_valid  out  1  alu_in holds a valid word.
- alu_in_ready  in  1  ALUs consume alu_in this cycle.
- in_index  out  IW  position of alu_in within the layer vector.
- in_last  out  1  alu_in is word NUM_INPUTS-1.
- layer_done  out  1  one-cycle pulse after the last word is consumed.
- ovf_err  out  1  sticky: word offered while full.

## Operation
- Push = shift_valid && shift_ready; pop = alu_in_valid && alu_in_ready.
- shift_ready = (count != FIFO_DEPTH). Independent of alu_in_ready: no push-through at full.
- alu_in_valid = (count != 0). alu_in is a combinational read of the head entry (first-word fall-through). alu_in is don't-care when not valid; the bench ignores it.
- Simultaneous push and pop: both take effect, count unchanged, order preserved.
- shift_valid while full: word dropped, ovf_err set, held until rst.
- Index counter idx, 0..NUM_INPUTS-1. Advances only on pop; wraps to 0 on a pop with in_last=1. in_index = idx; in_last = (idx == NUM_INPUTS-1).
- layer_done is a registered flag, 1 for exactly the cycle after a pop with in_last=1, else 0.
- Indexing is by consumption order only. Words are not inspected; no arithmetic on data.
- Reset (any time, including mid-layer): FIFO emptied (pointers and count 0), idx=0, layer_done=0, ovf_err=0. During and after reset: shift_ready=1, alu_in_valid=0, in_index=0, in_last=0. Words in flight are discarded.

## Timing
- Latency: word pushed at edge N is on alu_in with alu_in_valid=1 in the cycle after edge N.
- Throughput: one push and one pop per cycle.
- A pop at edge N updates in_index/in_last in the cycle after N. layer_done is high in the cycle after N when that pop had in_last=1.
- shift_ready falls in the cycle after the push that fills the FIFO, and rises in the cycle after the next pop.
- Async rst clears all state immediately. First push is accepted at the first rising edge with rst low.

## Structure
- Shared definitions include: W derivation, IW via clog2 function, EXTRA_BITS legality check.
- One sub-module, feeder_fifo: parameterized FWFT synchronous FIFO (mem, rd/wr pointers, count, full/empty).
- Top level holds the index counter, layer_done register and ovf_err flag.

## Test plan
- Reset: assert rst mid-cycle -> immediately shift_ready=1, alu_in_valid=0, in_index=0, in_last=0, layer_done=0, ovf_err=0.
- Normal flow (NUM_INPUTS=2, alu_in_ready=1): push 32'hAAAA_AAAA then 32'hBBBB_BBBB on consecutive cycles -> AAAA_AAAA with index 0/last 0, then BBBB_BBBB with index 1/last 1, then a layer_done pulse one cycle wide.
- Backpressure (alu_in_ready=0): push EEEE_EEE0..EEEE_EEE3 -> shift_ready=0 after the 4th. Offer FFFF_FFFF -> dropped, ovf_err=1. Raise ready -> EEE0..EEE3 drained in order, ovf_err stays 1.
- Simultaneous push/pop with count=2 -> count stays 2, FIFO order intact, in_index advances by one.
- Reset mid-layer after one pop (in_index=1) -> in_index=0 and FIFO empty. Next two pushes are indexed 0 and 1.
- NUM_INPUTS=3, EXTRA_BITS=2 (W=34): push six words with random ready -> indices 0,1,2,0,1,2 and two layer_done pulses.
